// File: rtl/core_pkg.sv
// Shared pipeline encodings: decoder hazard classes and operand forward selects.
// Imported by the hazard unit and its forward-select slices.
package core_pkg;

  typedef enum logic [1:0] {
    HZ_NONE  = 2'b00,
    HZ_ALU   = 2'b01,
    HZ_LOAD  = 2'b10,
    HZ_STORE = 2'b11
  } hz_optype_e;

  typedef enum logic [1:0] {
    FWD_RF      = 2'b00,
    FWD_EX      = 2'b01,
    FWD_MEM_ALU = 2'b10,
    FWD_MEM_LD  = 2'b11
  } fwd_sel_e;

endpackage

// File: rtl/fwd_sel.sv
// Combinational forward-select slice for one ALU operand.
// The youngest in-flight producer wins: EX ALU, then MEM ALU, then MEM load.
module fwd_sel
  import core_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              rs_use,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_ex,
  input  logic [REG_AW-1:0] rd_mem,
  input  hz_optype_e        optype_ex,
  input  hz_optype_e        optype_mem,
  output fwd_sel_e          fwd
);

  logic hit_ex;
  logic hit_mem;

  // x0 is hardwired zero, so it never matches a producer.
  assign hit_ex  = (rs == rd_ex)  && (rs != '0);
  assign hit_mem = (rs == rd_mem) && (rs != '0);

  always_comb begin
    fwd = FWD_RF;
    if (rs_use) begin
      if (optype_ex == HZ_ALU && hit_ex) begin
        fwd = FWD_EX;
      end else if (optype_mem == HZ_ALU && hit_mem) begin
        fwd = FWD_MEM_ALU;
      end else if (optype_mem == HZ_LOAD && hit_mem) begin
        fwd = FWD_MEM_LD;
      end
    end
  end

endmodule

// File: rtl/hazard_detect_unit.sv
// Decode-stage hazard resolver: tracks EX/MEM hazard classes, detects load-use
// stalls, drives pipeline enables/flushes and selects operand/store-data forwarding.
module hazard_detect_unit
  import core_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Branch_ID,
  input  logic              rs1use_ID,
  input  logic              rs2use_ID,
  input  logic [1:0]        hazard_optype_ID,
  input  logic [REG_AW-1:0] rs1_ID,
  input  logic [REG_AW-1:0] rs2_ID,
  input  logic [REG_AW-1:0] rd_EXE,
  input  logic [REG_AW-1:0] rd_MEM,
  input  logic [REG_AW-1:0] rs2_EXE,
  output logic              PC_EN_IF,
  output logic              reg_FD_EN,
  output logic              reg_FD_flush,
  output logic              reg_DE_EN,
  output logic              reg_DE_flush,
  output logic              reg_EM_EN,
  output logic              reg_EM_flush,
  output logic              reg_MW_EN,
  output logic [1:0]        forward_ctrl_A,
  output logic [1:0]        forward_ctrl_B,
  output logic              forward_ctrl_ls
);

  hz_optype_e optype_id;
  hz_optype_e optype_ex_q, optype_ex_d;
  hz_optype_e optype_mem_q, optype_mem_d;
  fwd_sel_e   fwd_a;
  fwd_sel_e   fwd_b;

  logic stall;
  logic rs1_hit_ex;
  logic rs2_hit_ex;
  logic st_hit_mem;

  assign optype_id = hz_optype_e'(hazard_optype_ID);

  assign rs1_hit_ex = (rs1_ID == rd_EXE) && (rs1_ID != '0);
  assign rs2_hit_ex = (rs2_ID == rd_EXE) && (rs2_ID != '0);
  assign st_hit_mem = (rs2_EXE == rd_MEM) && (rs2_EXE != '0);

  // A store's rs2 only needs the data at MEM, so it rides the ls forward instead of stalling.
  always_comb begin
    stall = 1'b0;
    if (optype_ex_q == HZ_LOAD) begin
      if (rs1use_ID && rs1_hit_ex) begin
        stall = 1'b1;
      end
      if (rs2use_ID && rs2_hit_ex && optype_id != HZ_STORE) begin
        stall = 1'b1;
      end
    end
  end

  always_comb begin
    optype_ex_d  = stall ? HZ_NONE : optype_id;
    optype_mem_d = optype_ex_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      optype_ex_q  <= HZ_NONE;
      optype_mem_q <= HZ_NONE;
    end else begin
      optype_ex_q  <= optype_ex_d;
      optype_mem_q <= optype_mem_d;
    end
  end

  // A stall beats a branch: the branch resolves next cycle once its operands are valid.
  always_comb begin
    PC_EN_IF     = 1'b1;
    reg_FD_EN    = 1'b1;
    reg_FD_flush = 1'b0;
    reg_DE_flush = 1'b0;
    if (stall) begin
      PC_EN_IF     = 1'b0;
      reg_FD_EN    = 1'b0;
      reg_DE_flush = 1'b1;
    end else if (Branch_ID) begin
      reg_FD_flush = 1'b1;
    end
  end

  assign reg_DE_EN    = 1'b1;
  assign reg_EM_EN    = 1'b1;
  assign reg_EM_flush = 1'b0;
  assign reg_MW_EN    = 1'b1;

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_use     (rs1use_ID),
    .rs         (rs1_ID),
    .rd_ex      (rd_EXE),
    .rd_mem     (rd_MEM),
    .optype_ex  (optype_ex_q),
    .optype_mem (optype_mem_q),
    .fwd        (fwd_a)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_use     (rs2use_ID),
    .rs         (rs2_ID),
    .rd_ex      (rd_EXE),
    .rd_mem     (rd_MEM),
    .optype_ex  (optype_ex_q),
    .optype_mem (optype_mem_q),
    .fwd        (fwd_b)
  );

  assign forward_ctrl_A  = fwd_a;
  assign forward_ctrl_B  = fwd_b;
  assign forward_ctrl_ls = (optype_ex_q == HZ_STORE) && (optype_mem_q == HZ_LOAD) && st_hit_mem;

endmodule
